// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flow-controlled pipeline stage register with a two-entry
// skid buffer. It carries NCH data channels plus a control bundle across one
// stage using a valid/ready handshake.
//
// o_ready is taken only from registered state, so there is no combinational
// path from i_ready to o_ready. Full throughput is still kept because the
// skid register absorbs the single beat that arrives while the stall is
// propagating back upstream.
//
// Ports:
//   clk          single clock; all state updates on its rising edge
//   rst          asynchronous active-low reset
//   i_valid      upstream offers a beat
//   o_ready      stage can accept a beat this cycle
//   i_data       NCH channels; channel k at [k*DATA_W +: DATA_W]
//   i_ctrl       control bundle travelling with the beat
//   o_valid      stage presents a beat downstream
//   i_ready      downstream accepts the presented beat
//   o_data       presented data
//   o_ctrl       presented control; zero while o_valid=0 (bubble)
//   i_flush      synchronous squash (only when PIPE_FLUSH_EN is defined)
//   o_stall_cnt  saturating count of cycles with o_valid=1 and i_ready=0
//
// Build option: define PIPE_FLUSH_EN to add the i_flush port.
//
// state    | meaning
// ---------+----------------------------------
// ST_EMPTY | main and skid registers invalid
// ST_ONE   | main register valid
// ST_TWO   | main and skid registers valid

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pipe_stage_reg #(
    parameter int DATA_W = `DATA_WIDTH,
    parameter int NCH    = 3,
    parameter int CTRL_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [NCH*DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0]     i_ctrl,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [NCH*DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0]     o_ctrl,
`ifdef PIPE_FLUSH_EN
    input  logic                  i_flush,
`endif
    output logic [15:0]           o_stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [NCH*DATA_W-1:0] m_data;
    logic [CTRL_W-1:0]     m_ctrl;
    logic [NCH*DATA_W-1:0] s_data;
    logic [CTRL_W-1:0]     s_ctrl;
    logic [15:0]           stall_cnt;

    logic flush;
    logic accept;
    logic take;
    logic m_from_in;
    logic m_from_s;
    logic s_from_in;

`ifdef PIPE_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    assign o_ready = (state != ST_TWO);
    assign o_valid = (state != ST_EMPTY);
    assign accept  = i_valid & o_ready;
    assign take    = o_valid & i_ready;

    always_comb begin
        state_nxt = state;
        m_from_in = 1'b0;
        m_from_s  = 1'b0;
        s_from_in = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    m_from_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && take) begin
                    m_from_in = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_TWO;
                    s_from_in = 1'b1;
                end else if (take) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (take) begin
                    state_nxt = ST_ONE;
                    m_from_s  = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Flush overrides any accept/take in the same cycle; the offered beat is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_EMPTY;
            m_data <= '0;
            m_ctrl <= '0;
            s_data <= '0;
            s_ctrl <= '0;
        end else if (flush) begin
            state  <= ST_EMPTY;
            m_data <= '0;
            m_ctrl <= '0;
            s_data <= '0;
            s_ctrl <= '0;
        end else begin
            state <= state_nxt;
            if (m_from_in) begin
                m_data <= i_data;
                m_ctrl <= i_ctrl;
            end else if (m_from_s) begin
                m_data <= s_data;
                m_ctrl <= s_ctrl;
            end
            if (s_from_in) begin
                s_data <= i_data;
                s_ctrl <= i_ctrl;
            end
        end
    end

    // Counts back-pressure independently of flush; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (o_valid && !i_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign o_data      = m_data;
    assign o_ctrl      = o_valid ? m_ctrl : '0;
    assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int DW  = 32;
    localparam int NCH = 3;
    localparam int CW  = 6;
    localparam int TW  = NCH * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [TW-1:0] i_data;
    logic [CW-1:0] i_ctrl;
    logic          o_valid;
    logic          i_ready;
    logic [TW-1:0] o_data;
    logic [CW-1:0] o_ctrl;
    logic          flush_drv;
    logic [15:0]   o_stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .NCH(NCH), .CTRL_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_ctrl      (i_ctrl),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_ctrl      (o_ctrl),
`ifdef PIPE_FLUSH_EN
        .i_flush     (flush_drv),
`endif
        .o_stall_cnt (o_stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the stage is a FIFO of depth two plus a saturating counter.
    typedef struct {
        logic [TW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t       q[$];
    int unsigned stall_m;
    bit          cleared_m;

    typedef struct {
        logic          v;
        logic          r;
        logic [7:0]    d0;
        logic [CW-1:0] c;
        logic          ev;
        logic          er;
        logic [7:0]    ed;
        logic [CW-1:0] ec;
        logic [15:0]   es;
    } vec_t;

    vec_t tbl[13];

    task automatic cmp(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] pat(input logic [7:0] b);
        return {NCH{24'h0, b}};
    endfunction

    task automatic model_reset();
        q.delete();
        stall_m   = 0;
        cleared_m = 1'b1;
    endtask

    task automatic drive(input logic v, input logic r, input logic [TW-1:0] d,
                         input logic [CW-1:0] c, input logic f);
        i_valid   = v;
        i_ready   = r;
        i_data    = d;
        i_ctrl    = c;
        flush_drv = f;
    endtask

    task automatic advance();
        bit    acc;
        bit    tk;
        bit    fl;
        bit    stl;
        beat_t b;
        acc = i_valid && (q.size() < 2);
        tk  = (q.size() > 0) && i_ready;
        stl = (q.size() > 0) && !i_ready;
`ifdef PIPE_FLUSH_EN
        fl  = flush_drv;
`else
        fl  = 1'b0;
`endif
        b.d = i_data;
        b.c = i_ctrl;
        @(posedge clk);
        if (stl && stall_m != 32'd65535) stall_m++;
        if (fl) begin
            q.delete();
            cleared_m = 1'b1;
        end else begin
            if (tk) void'(q.pop_front());
            if (acc) begin
                q.push_back(b);
                cleared_m = 1'b0;
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        cmp({tag, " valid"}, o_valid, q.size() > 0);
        cmp({tag, " ready"}, o_ready, q.size() < 2);
        cmp({tag, " stall"}, o_stall_cnt, stall_m[15:0]);
        if (q.size() > 0) begin
            cmp({tag, " data"}, o_data, q[0].d);
            cmp({tag, " ctrl"}, o_ctrl, q[0].c);
        end else begin
            cmp({tag, " ctrl"}, o_ctrl, '0);
            if (cleared_m) cmp({tag, " data"}, o_data, '0);
        end
    endtask

    initial begin
        // Streaming, drain/bubble, then back-pressure A/B/C. Expectations are
        // the outputs seen before the edge that consumes the row's inputs.
        tbl[0]  = '{1'b1, 1'b1, 8'h11, 6'h01, 1'b0, 1'b1, 8'h00, 6'h00, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 8'h22, 6'h02, 1'b1, 1'b1, 8'h11, 6'h01, 16'd0};
        tbl[2]  = '{1'b1, 1'b1, 8'h33, 6'h03, 1'b1, 1'b1, 8'h22, 6'h02, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 8'h00, 6'h3F, 1'b1, 1'b1, 8'h33, 6'h03, 16'd0};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 6'h3F, 1'b0, 1'b1, 8'h00, 6'h00, 16'd0};
        tbl[5]  = '{1'b1, 1'b0, 8'hA0, 6'h0A, 1'b0, 1'b1, 8'h00, 6'h00, 16'd0};
        tbl[6]  = '{1'b1, 1'b0, 8'hB0, 6'h0B, 1'b1, 1'b1, 8'hA0, 6'h0A, 16'd0};
        tbl[7]  = '{1'b1, 1'b0, 8'hC0, 6'h0C, 1'b1, 1'b0, 8'hA0, 6'h0A, 16'd1};
        tbl[8]  = '{1'b1, 1'b0, 8'hC0, 6'h0C, 1'b1, 1'b0, 8'hA0, 6'h0A, 16'd2};
        tbl[9]  = '{1'b1, 1'b1, 8'hC0, 6'h0C, 1'b1, 1'b0, 8'hA0, 6'h0A, 16'd3};
        tbl[10] = '{1'b1, 1'b1, 8'hC0, 6'h0C, 1'b1, 1'b1, 8'hB0, 6'h0B, 16'd3};
        tbl[11] = '{1'b0, 1'b1, 8'h00, 6'h3F, 1'b1, 1'b1, 8'hC0, 6'h0C, 16'd3};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 6'h3F, 1'b0, 1'b1, 8'h00, 6'h00, 16'd3};

        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '1, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("reset valid", o_valid, 1'b0);
        cmp("reset ready", o_ready, 1'b1);
        cmp("reset data", o_data, '0);
        cmp("reset ctrl", o_ctrl, '0);
        cmp("reset stall", o_stall_cnt, '0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].r, pat(tbl[i].d0), tbl[i].c, 1'b0);
            @(negedge clk);
            cmp($sformatf("tbl%0d valid", i), o_valid, tbl[i].ev);
            cmp($sformatf("tbl%0d ready", i), o_ready, tbl[i].er);
            cmp($sformatf("tbl%0d ctrl", i), o_ctrl, tbl[i].ec);
            cmp($sformatf("tbl%0d stall", i), o_stall_cnt, tbl[i].es);
            if (tbl[i].ev) cmp($sformatf("tbl%0d data", i), o_data, pat(tbl[i].ed));
            advance();
        end

        // Asynchronous reset between edges while in TWO.
        drive(1'b1, 1'b0, pat(8'h51), 6'h11, 1'b0);
        advance();
        drive(1'b1, 1'b0, pat(8'h52), 6'h12, 1'b0);
        advance();
        drive(1'b1, 1'b0, pat(8'h53), 6'h13, 1'b0);
        @(negedge clk);
        check_model("pre-reset");
        cmp("pre-reset in TWO", o_ready, 1'b0);
        #2 rst = 1'b0;
        #1;
        cmp("async rst valid", o_valid, 1'b0);
        cmp("async rst ready", o_ready, 1'b1);
        cmp("async rst data", o_data, '0);
        cmp("async rst ctrl", o_ctrl, '0);
        cmp("async rst stall", o_stall_cnt, '0);
        model_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

`ifdef PIPE_FLUSH_EN
        begin
            int unsigned s_before;
            drive(1'b1, 1'b0, pat(8'h61), 6'h21, 1'b0);
            advance();
            drive(1'b1, 1'b0, pat(8'h62), 6'h22, 1'b0);
            advance();
            s_before = stall_m;
            drive(1'b1, 1'b1, pat(8'h63), 6'h23, 1'b1);
            @(negedge clk);
            check_model("pre-flush");
            advance();
            drive(1'b0, 1'b1, '0, '0, 1'b0);
            @(negedge clk);
            cmp("flush valid", o_valid, 1'b0);
            cmp("flush data", o_data, '0);
            cmp("flush ready", o_ready, 1'b1);
            cmp("flush stall", o_stall_cnt, s_before[15:0]);
            for (int k = 0; k < 3; k++) begin
                advance();
                @(negedge clk);
                cmp("flush dropped beat absent", o_valid, 1'b0);
            end
            advance();
        end
`endif

        // Randomized traffic against the FIFO model.
        for (int n = 0; n < 3000; n++) begin
            logic          v;
            logic          f;
            logic [TW-1:0] d;
            logic [CW-1:0] c;
            if (i_valid && q.size() == 2) begin
                v = 1'b1;
                d = i_data;
                c = i_ctrl;
            end else begin
                v = 1'($urandom_range(0, 3) != 0);
                d = {$urandom, $urandom, $urandom};
                c = CW'($urandom);
            end
`ifdef PIPE_FLUSH_EN
            f = 1'($urandom_range(0, 24) == 0);
`else
            f = 1'b0;
`endif
            drive(v, 1'($urandom_range(0, 2) != 0), d, c, f);
            @(negedge clk);
            check_model("rand");
            advance();
        end

        // Saturation from a fresh reset: one accept, then sustained stall.
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 1'b0, pat(8'h77), 6'h07, 1'b0);
        advance();
        drive(1'b0, 1'b0, '0, '1, 1'b0);
        for (int n = 0; n < 65534; n++) advance();
        @(negedge clk);
        cmp("sat minus one", o_stall_cnt, 16'hFFFE);
        advance();
        @(negedge clk);
        cmp("sat reached", o_stall_cnt, 16'hFFFF);
        for (int n = 0; n < 4465; n++) advance();
        @(negedge clk);
        cmp("sat held", o_stall_cnt, 16'hFFFF);
        check_model("sat");
        drive(1'b0, 1'b1, '0, '0, 1'b0);
        advance();
        @(negedge clk);
        check_model("sat drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register for the MIPS pipeline; the generic successor to the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries NCH data channels plus a control bundle across one stage with a valid/ready handshake. A two-entry skid buffer keeps full throughput while `o_ready` stays registered. A synchronous flush is available for branch/exception squash.

## Interface
- `DATA_W`, default `` `DATA_WIDTH `` (32): width of each data channel.
- `NCH`, default 3: number of data channels (e.g. result, rt, wdata).
- `CTRL_W`, default 6: control bundle width (M, WB, zero flag).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset; clears all state immediately.
- `i_valid` input 1: upstream offers a beat.
- `o_ready` output 1: stage can accept a beat this cycle.
- `i_data` input NCH*DATA_W: channel k at bits [k*DATA_W +: DATA_W].
- `i_ctrl` input CTRL_W: control bundle travelling with the beat.
- `o_valid` output 1: stage presents a beat downstream.
- `i_ready` input 1: downstream accepts the presented beat.
- `o_data` output NCH*DATA_W: presented data.
- `o_ctrl` output CTRL_W: presented control; forced to 0 whenever `o_valid`=0 (bubble).
- `i_flush` input 1: synchronous squash. Present only with `PIPE_FLUSH_EN`.
- `o_stall_cnt` output 16: saturating count of back-pressure cycles.

## Operation
- Storage: main register (M) drives the outputs; skid register (S) holds overflow.
- States:
  - EMPTY: M and S invalid.
  - ONE: M valid.
  - TWO: M and S valid.
- Handshake terms: accept = `i_valid` & `o_ready`; take = `o_valid` & `i_ready`.
- `o_ready` = (state != TWO). It comes from registered state only; there is no combinational path from `i_ready`.
- `o_valid` = (state != EMPTY).
- EMPTY: accept -> ONE, beat loaded into M.
- ONE:
  - accept & take -> ONE, M loaded with the new beat.
  - accept & !take -> TWO, beat loaded into S.
  - take & !accept -> EMPTY.
  - otherwise hold.
- TWO (no accept possible):
  - take -> ONE, S moved into M.
  - otherwise hold.
- Ordering: strict FIFO; no beat is dropped or duplicated except by flush.
- Stall counter: increments when `o_valid` & !`i_ready`. It saturates at 0xFFFF and holds there. It is cleared only by `rst`; flush does not clear it.
- Reset (`rst`=0, any time, including mid-transfer):
  - state = EMPTY; M, S data and ctrl = 0.
  - `o_valid`=0, `o_ready`=1, `o_data`=0, `o_ctrl`=0, `o_stall_cnt`=0.
- Reset deassertion: first accept can occur on the first rising edge with `rst`=1.

## Timing
- Latency: a beat accepted at edge N is presented (`o_valid`=1) after edge N. That is one cycle, from EMPTY or from ONE with simultaneous take.
- Throughput: one beat per cycle while `i_ready`=1 continuously.
- After `i_ready` drops: one more beat is absorbed into S, then `o_ready`=0 from the next cycle.
- After `i_ready` returns high in TWO:
  - S beat is presented the cycle after the take.
  - `o_ready` rises in that same cycle.
- Upstream rule: while `i_valid`=1 & `o_ready`=0, upstream must hold `i_data`/`i_ctrl` stable.
- The stage itself never withdraws `o_valid` without a take, except on flush or reset.

## Configuration
- `PIPE_FLUSH_EN` defined:
  - `i_flush` port exists.
  - `i_flush`=1 at an edge forces state = EMPTY and clears M/S data and ctrl to 0, overriding any accept/take that cycle.
  - The input beat offered in that cycle is dropped, and `o_ready`=1 on the next cycle.
- `PIPE_FLUSH_EN` undefined: no `i_flush` port; the stage is squashed only by `rst`.

## Test plan
- Streaming: `i_ready`=1, send 0x11,0x22,0x33 on channel 0 in consecutive cycles.
  - Required: same values on `o_data` one cycle later each.
  - Required: `o_ready` stays 1; `o_stall_cnt`=0.
- Back-pressure: `i_ready`=0 while sending A, B, C.
  - Required: A in M, B in S, `o_ready`=0 after B, C held upstream.
  - Then `i_ready`=1: output order A, B, C with no gaps after the first take.
  - Required: `o_stall_cnt` equals the number of cycles with `o_valid`=1 & `i_ready`=0.
- Bubble control: `i_valid`=0 with `i_ctrl`=all-ones.
  - Required: `o_valid`=0, `o_ctrl`=0.
- Flush (macro on): assert `i_flush` in state TWO while `i_valid`=1.
  - Required next cycle: `o_valid`=0, `o_data`=0, `o_ready`=1; the dropped beat never appears; `o_stall_cnt` unchanged.
- Async reset mid-operation: drop `rst` between edges in state TWO.
  - Required immediately: `o_valid`=0, `o_ready`=1, all data/ctrl 0, `o_stall_cnt`=0.
- Saturation: hold `o_valid`=1, `i_ready`=0 for 70000 cycles.
  - Required: `o_stall_cnt` = 0xFFFF and stays there.
